// File: rtl/div_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_counter_ctrl_if
//  Description : Control/status bundle for the prescaled period counter.
//                The controller side uses the slave modport; the driver of
//                start/stop/pause and configuration uses the master modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_counter_ctrl_if;
    logic       start_i;
    logic       stop_i;
    logic       pause_i;
    logic       mode_i;
    logic [3:0] prescale_i;
    logic [7:0] period_i;
    logic [7:0] count_o;
    logic       tick_o;
    logic       tc_o;
    logic       done_o;
    logic       busy_o;
    logic [1:0] state_o;

    modport master (
        output start_i, stop_i, pause_i, mode_i, prescale_i, period_i,
        input  count_o, tick_o, tc_o, done_o, busy_o, state_o
    );

    modport slave (
        input  start_i, stop_i, pause_i, mode_i, prescale_i, period_i,
        output count_o, tick_o, tc_o, done_o, busy_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/div_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_counter_ctrl
//  Description : Prescaled up-counter with one-shot / periodic auto-reload
//                modes, pause and abort control. tick_o and tc_o are
//                combinational single-cycle pulses; state, count and done
//                are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module div_counter_ctrl (
    input  wire               clk_i,
    input  wire               rst_i,
    div_counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_pre_cnt;
    logic [7:0] r_count;
    logic       r_done;
    logic       r_cfg_mode;
    logic [3:0] r_cfg_prescale;
    logic [7:0] r_cfg_period;

    logic       w_run_active;
    logic       w_tick;
    logic       w_tc;

    // Counting only advances in RUN when neither reset, abort nor pause is
    // requested this cycle; those all suppress the tick combinationally.
    always_comb begin
        w_run_active = !rst_i && (r_state == RUN) && !bus.stop_i && !bus.pause_i;
        w_tick       = w_run_active && (r_pre_cnt == r_cfg_prescale);
        w_tc         = w_tick && (r_count == r_cfg_period);
    end

    // Controller FSM with prescaler, counter and latched configuration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_pre_cnt      <= 4'd0;
            r_count        <= 8'd0;
            r_done         <= 1'b0;
            r_cfg_mode     <= 1'b0;
            r_cfg_prescale <= 4'd0;
            r_cfg_period   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    // Abort wins over a simultaneous start; count keeps its
                    // last value while idle.
                    if (bus.start_i && !bus.stop_i) begin
                        r_cfg_mode     <= bus.mode_i;
                        r_cfg_prescale <= bus.prescale_i;
                        r_cfg_period   <= bus.period_i;
                        r_pre_cnt      <= 4'd0;
                        r_count        <= 8'd0;
                        r_state        <= RUN;
                    end
                end

                RUN: begin
                    if (bus.stop_i) begin
                        r_pre_cnt <= 4'd0;
                        r_count   <= 8'd0;
                        r_state   <= IDLE;
                    end else if (bus.pause_i) begin
                        r_state <= PAUSE;
                    end else if (w_tick) begin
                        r_pre_cnt <= 4'd0;
                        if (w_tc) begin
                            if (r_cfg_mode) begin
                                r_count <= 8'd0;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_count <= r_count + 8'd1;
                        end
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 4'd1;
                    end
                end

                PAUSE: begin
                    if (bus.stop_i) begin
                        r_pre_cnt <= 4'd0;
                        r_count   <= 8'd0;
                        r_state   <= IDLE;
                    end else if (!bus.pause_i) begin
                        r_state <= RUN;
                    end
                end

                DONE: begin
                    // Completion is a single-cycle state; an abort here also
                    // discards the final count.
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                    if (bus.stop_i) begin
                        r_pre_cnt <= 4'd0;
                        r_count   <= 8'd0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs; busy and the pulses are forced low during reset.
    always_comb begin
        bus.count_o = r_count;
        bus.tick_o  = w_tick;
        bus.tc_o    = w_tc;
        bus.done_o  = r_done;
        bus.busy_o  = !rst_i && ((r_state == RUN) || (r_state == PAUSE));
        bus.state_o = r_state;
    end

endmodule
`default_nettype wire

// File: tb/tb_div_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_counter_ctrl
//  Description : Directed, self-checking bench for div_counter_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_counter_ctrl;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    logic [7:0] e_cnt;
    logic       e_tick;
    logic       e_tc;
    logic [1:0] e_state;

    div_counter_ctrl_if bus ();

    div_counter_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    // Pulse stop for one cycle to return to IDLE between scenarios.
    task automatic stop_run;
        bus.stop_i = 1'b1;
        adv();
        bus.stop_i = 1'b0;
    endtask

    task automatic start_run(input logic m, input logic [3:0] ps, input logic [7:0] pd);
        bus.mode_i     = m;
        bus.prescale_i = ps;
        bus.period_i   = pd;
        bus.start_i    = 1'b1;
        adv();
        bus.start_i    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start_i = 1'b1;
        #1;
        vecs++;
        if ({bus.busy_o, bus.tick_o, bus.tc_o} !== 3'b000) begin
            errs++;
            $display("FAIL reset_pulses: got busy/tick/tc=%b expected 000", {bus.busy_o, bus.tick_o, bus.tc_o});
        end
        adv();
        #1;
        vecs++;
        if ({bus.state_o, bus.count_o, bus.done_o, bus.busy_o} !== {2'd0, 8'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_state: got state=%0d count=%0d done=%b busy=%b expected 0 0 0 0",
                     bus.state_o, bus.count_o, bus.done_o, bus.busy_o);
        end
        adv();
        rst = 1'b0;
        bus.start_i = 1'b0;
        adv();
    endtask

    task automatic test_periodic;
        start_run(1'b1, 4'd1, 8'd3);
        for (int k = 1; k <= 20; k++) begin
            #1;
            e_cnt  = 8'(((k - 1) / 2) % 4);
            e_tick = (k % 2 == 0);
            e_tc   = (k % 8 == 0);
            vecs++;
            if ({bus.state_o, bus.busy_o, bus.count_o, bus.tick_o, bus.tc_o} !== {2'd1, 1'b1, e_cnt, e_tick, e_tc}) begin
                errs++;
                $display("FAIL periodic k=%0d: got state=%0d busy=%b count=%0d tick=%b tc=%b expected 1 1 %0d %b %b",
                         k, bus.state_o, bus.busy_o, bus.count_o, bus.tick_o, bus.tc_o, e_cnt, e_tick, e_tc);
            end
            adv();
        end
        stop_run();
    endtask

    task automatic test_oneshot;
        start_run(1'b0, 4'd0, 8'd5);
        for (int k = 1; k <= 6; k++) begin
            #1;
            e_cnt = 8'(k - 1);
            e_tc  = (k == 6);
            vecs++;
            if ({bus.state_o, bus.count_o, bus.tick_o, bus.tc_o, bus.done_o} !== {2'd1, e_cnt, 1'b1, e_tc, 1'b0}) begin
                errs++;
                $display("FAIL oneshot k=%0d: got state=%0d count=%0d tick=%b tc=%b done=%b expected 1 %0d 1 %b 0",
                         k, bus.state_o, bus.count_o, bus.tick_o, bus.tc_o, bus.done_o, e_cnt, e_tc);
            end
            adv();
        end
        #1;
        vecs++;
        if ({bus.state_o, bus.done_o, bus.busy_o, bus.count_o, bus.tick_o, bus.tc_o} !== {2'd3, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL oneshot_done: got state=%0d done=%b busy=%b count=%0d tick=%b tc=%b expected 3 1 0 5 0 0",
                     bus.state_o, bus.done_o, bus.busy_o, bus.count_o, bus.tick_o, bus.tc_o);
        end
        adv();
        for (int k = 0; k < 2; k++) begin
            #1;
            vecs++;
            if ({bus.state_o, bus.done_o, bus.count_o} !== {2'd0, 1'b0, 8'd5}) begin
                errs++;
                $display("FAIL oneshot_idle: got state=%0d done=%b count=%0d expected 0 0 5",
                         bus.state_o, bus.done_o, bus.count_o);
            end
            adv();
        end
    endtask

    task automatic test_pause;
        start_run(1'b1, 4'd2, 8'd7);
        for (int k = 1; k <= 7; k++) begin
            #1;
            e_cnt  = 8'((k - 1) / 3);
            e_tick = (k % 3 == 0);
            vecs++;
            if ({bus.count_o, bus.tick_o} !== {e_cnt, e_tick}) begin
                errs++;
                $display("FAIL pause_pre k=%0d: got count=%0d tick=%b expected %0d %b",
                         k, bus.count_o, bus.tick_o, e_cnt, e_tick);
            end
            adv();
        end
        // Cycle 8: count=2, prescaler mid-phase. Hold pause for 7 cycles.
        bus.pause_i = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            #1;
            e_state = (p == 1) ? 2'd1 : 2'd2;
            vecs++;
            if ({bus.state_o, bus.busy_o, bus.count_o, bus.tick_o, bus.tc_o} !== {e_state, 1'b1, 8'd2, 1'b0, 1'b0}) begin
                errs++;
                $display("FAIL pause_hold p=%0d: got state=%0d busy=%b count=%0d tick=%b tc=%b expected %0d 1 2 0 0",
                         p, bus.state_o, bus.busy_o, bus.count_o, bus.tick_o, bus.tc_o, e_state);
            end
            adv();
        end
        bus.pause_i = 1'b0;
        #1;
        vecs++;
        if ({bus.state_o, bus.count_o, bus.tick_o} !== {2'd2, 8'd2, 1'b0}) begin
            errs++;
            $display("FAIL pause_release: got state=%0d count=%0d tick=%b expected 2 2 0",
                     bus.state_o, bus.count_o, bus.tick_o);
        end
        adv();
        // Prescaler was frozen at 1 of 0..2: one quiet cycle, then the tick.
        for (int r = 1; r <= 3; r++) begin
            #1;
            e_cnt  = (r == 3) ? 8'd3 : 8'd2;
            e_tick = (r == 2);
            vecs++;
            if ({bus.state_o, bus.count_o, bus.tick_o} !== {2'd1, e_cnt, e_tick}) begin
                errs++;
                $display("FAIL pause_resume r=%0d: got state=%0d count=%0d tick=%b expected 1 %0d %b",
                         r, bus.state_o, bus.count_o, bus.tick_o, e_cnt, e_tick);
            end
            adv();
        end
        stop_run();
    endtask

    task automatic test_stop_collision;
        start_run(1'b1, 4'd0, 8'd9);
        for (int k = 1; k <= 4; k++) adv();
        bus.stop_i = 1'b1;
        #1;
        vecs++;
        if ({bus.state_o, bus.count_o, bus.tick_o, bus.tc_o} !== {2'd1, 8'd4, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL stop_cycle: got state=%0d count=%0d tick=%b tc=%b expected 1 4 0 0",
                     bus.state_o, bus.count_o, bus.tick_o, bus.tc_o);
        end
        adv();
        bus.start_i = 1'b1;
        #1;
        vecs++;
        if ({bus.state_o, bus.count_o, bus.tick_o, bus.tc_o, bus.busy_o} !== {2'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL stop_idle: got state=%0d count=%0d tick=%b tc=%b busy=%b expected 0 0 0 0 0",
                     bus.state_o, bus.count_o, bus.tick_o, bus.tc_o, bus.busy_o);
        end
        adv();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vecs++;
            if ({bus.state_o, bus.count_o, bus.busy_o} !== {2'd0, 8'd0, 1'b0}) begin
                errs++;
                $display("FAIL collision_norestart k=%0d: got state=%0d count=%0d busy=%b expected 0 0 0",
                         k, bus.state_o, bus.count_o, bus.busy_o);
            end
            adv();
        end
    endtask

    task automatic test_boundaries;
        // period 0, slowest prescaler: tc on every tick, count pinned at 0.
        start_run(1'b1, 4'd15, 8'd0);
        for (int k = 1; k <= 34; k++) begin
            #1;
            e_tick = (k % 16 == 0);
            vecs++;
            if ({bus.count_o, bus.tick_o, bus.tc_o} !== {8'd0, e_tick, e_tick}) begin
                errs++;
                $display("FAIL bound_p0 k=%0d: got count=%0d tick=%b tc=%b expected 0 %b %b",
                         k, bus.count_o, bus.tick_o, bus.tc_o, e_tick, e_tick);
            end
            adv();
        end
        stop_run();
        // Full 8-bit period with configuration scrambled after the start.
        start_run(1'b1, 4'd0, 8'd255);
        bus.mode_i     = 1'b0;
        bus.prescale_i = 4'd5;
        bus.period_i   = 8'd1;
        for (int k = 1; k <= 258; k++) begin
            bus.start_i = (k == 10);
            #1;
            e_cnt = 8'((k - 1) % 256);
            e_tc  = (k == 256);
            vecs++;
            if ({bus.state_o, bus.count_o, bus.tick_o, bus.tc_o} !== {2'd1, e_cnt, 1'b1, e_tc}) begin
                errs++;
                $display("FAIL bound_p255 k=%0d: got state=%0d count=%0d tick=%b tc=%b expected 1 %0d 1 %b",
                         k, bus.state_o, bus.count_o, bus.tick_o, bus.tc_o, e_cnt, e_tc);
            end
            adv();
        end
        bus.start_i = 1'b0;
        stop_run();
    endtask

    task automatic test_reset_mid;
        start_run(1'b0, 4'd0, 8'd9);
        for (int k = 1; k <= 7; k++) adv();
        rst = 1'b1;
        bus.start_i = 1'b1;
        #1;
        vecs++;
        if ({bus.count_o, bus.busy_o, bus.tick_o, bus.tc_o} !== {8'd7, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL rst_run_cycle: got count=%0d busy=%b tick=%b tc=%b expected 7 0 0 0",
                     bus.count_o, bus.busy_o, bus.tick_o, bus.tc_o);
        end
        adv();
        rst = 1'b0;
        bus.start_i = 1'b0;
        #1;
        vecs++;
        if ({bus.state_o, bus.count_o, bus.done_o, bus.busy_o} !== {2'd0, 8'd0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL rst_run_after: got state=%0d count=%0d done=%b busy=%b expected 0 0 0 0",
                     bus.state_o, bus.count_o, bus.done_o, bus.busy_o);
        end
        adv();
        start_run(1'b0, 4'd0, 8'd2);
        for (int k = 1; k <= 3; k++) adv();
        rst = 1'b1;
        #1;
        vecs++;
        if ({bus.state_o, bus.busy_o, bus.tick_o, bus.tc_o} !== {2'd3, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL rst_done_cycle: got state=%0d busy=%b tick=%b tc=%b expected 3 0 0 0",
                     bus.state_o, bus.busy_o, bus.tick_o, bus.tc_o);
        end
        adv();
        rst = 1'b0;
        #1;
        vecs++;
        if ({bus.state_o, bus.count_o, bus.done_o} !== {2'd0, 8'd0, 1'b0}) begin
            errs++;
            $display("FAIL rst_done_after: got state=%0d count=%0d done=%b expected 0 0 0",
                     bus.state_o, bus.count_o, bus.done_o);
        end
        adv();
    endtask

    initial begin
        vecs           = 0;
        errs           = 0;
        rst            = 1'b0;
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.pause_i    = 1'b0;
        bus.mode_i     = 1'b0;
        bus.prescale_i = 4'd0;
        bus.period_i   = 8'd0;
        #1;
        test_reset();
        test_periodic();
        test_oneshot();
        test_pause();
        test_stop_collision();
        test_boundaries();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
